if_fetch_queue: RTL and testbench

//  Fetch stage upstream of the IF/ID register. Owns the program counter, drives the combinational

---
 rtl/if_fetch_queue_pkg.sv | 12 +
 rtl/if_fetch_queue_if.sv | 24 ++
 rtl/if_fetch_queue_fifo.sv | 39 +++
 rtl/if_fetch_queue.sv | 54 +++++
 tb/tb_if_fetch_queue.sv | 127 ++++++++++++
 5 files changed

// File: rtl/if_fetch_queue_pkg.sv
// pipe_pkg: shared fetch-pipeline constants and the prefetch entry type.
package pipe_pkg;
  localparam int IFQ_AW = 8;
  localparam int IFQ_IW = 32;
  localparam int IFQ_DEPTH = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int PC_STEP = 4;
  typedef struct packed {
    logic [IFQ_IW-1:0] instr;
    logic [IFQ_AW-1:0] pc_plus4;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: ROM, branch-redirect and IF/ID hand-off signals of the fetch queue.
interface if_fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW = 8,
  parameter int IW = 32
);
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_instr;
  logic id_le;
  logic br_take;
  logic [AW-1:0] br_target;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc_plus4;
  logic out_valid;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  modport master (
    input rom_instr, id_le, br_take, br_target,
    output rom_addr, out_instr, out_pc_plus4, out_valid, occupancy
  );
  modport slave (
    output rom_instr, id_le, br_take, br_target,
    input rom_addr, out_instr, out_pc_plus4, out_valid, occupancy
  );
endinterface

// File: rtl/if_fetch_queue_fifo.sv
// ifq_fifo: prefetch FIFO storage with wrapping pointers and an occupancy count.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter type T = logic
) (
  input  logic clk,
  input  logic R_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  T wdata,
  output T rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  T mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // Payload needs no reset: it is only visible while count marks it valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC owner and prefetch buffer feeding IF/ID; branch flushes and redirects.
// IFQ_BYPASS_EN: when defined, an empty queue presents the ROM word directly (zero-latency fetch).
module if_fetch_queue
  import pipe_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW = IFQ_AW,
  parameter int IW = IFQ_IW
) (
  input  logic clk,
  input  logic R_n,
  if_fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);
  logic [AW-1:0] pc, pc_plus4;
  logic [CW-1:0] count;
  logic empty, byp, valid, push, pop, adv;
  fetch_entry_t wdata, rdata, head;
  assign pc_plus4 = pc + AW'(PC_STEP);
  assign empty = count == '0;
  assign wdata = '{instr: bus.rom_instr, pc_plus4: pc_plus4};
`ifdef IFQ_BYPASS_EN
  // R_n gate keeps the head invalid while reset is held.
  assign byp = empty & ~bus.br_take & R_n;
`else
  assign byp = 1'b0;
`endif
  assign valid = ~bus.br_take & (~empty | byp);
  assign pop = bus.id_le & valid & ~empty;
  // A bypassed word consumed this cycle never enters the FIFO.
  assign push = ~bus.br_take & (count < CW'(DEPTH) | pop) & ~(byp & bus.id_le);
  assign adv = push | (byp & bus.id_le);
  assign head = byp ? wdata : rdata;
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) pc <= '0;
    else if (bus.br_take) pc <= bus.br_target;
    else if (adv) pc <= pc_plus4;
  end
  ifq_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk(clk),
    .R_n(R_n),
    .push(push),
    .pop(pop),
    .flush(bus.br_take),
    .wdata(wdata),
    .rdata(rdata),
    .count(count)
  );
  assign bus.rom_addr = pc;
  assign bus.out_valid = valid;
  assign bus.out_instr = valid ? head.instr : NOP_INSTR;
  assign bus.out_pc_plus4 = valid ? head.pc_plus4 : '0;
  assign bus.occupancy = count;
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed scenarios plus random traffic against a queue-based fetch model.
module tb_if_fetch_queue;
  import pipe_pkg::*;
  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic R_n = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  logic [7:0] m_pc = 8'h00;
  fetch_entry_t q[$];
  if_fetch_queue_if #(.DEPTH(DEPTH), .AW(8), .IW(32)) bus ();
  if_fetch_queue #(.DEPTH(DEPTH), .AW(8), .IW(32)) dut (
    .clk(clk),
    .R_n(R_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.rom_instr = {24'hA5A5A5, bus.rom_addr};
  function automatic logic [31:0] rom(input logic [7:0] a);
    return {24'hA5A5A5, a};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Entered at a falling edge; checks this cycle's outputs, advances the model, returns at the next falling edge.
  task automatic step(input bit le, input bit br, input logic [7:0] tgt);
    bit e_valid, from_q, took;
    logic [31:0] e_instr;
    logic [7:0] e_p4;
    int n;
    bus.id_le = le;
    bus.br_take = br;
    bus.br_target = tgt;
    #1;
    n = q.size();
    from_q = !br && n > 0;
    e_valid = from_q || (!br && BYP);
    e_instr = from_q ? q[0].instr : (e_valid ? rom(m_pc) : 32'h0);
    e_p4 = from_q ? q[0].pc_plus4 : (e_valid ? m_pc + 8'd4 : 8'h00);
    check("rom_addr", bus.rom_addr, m_pc);
    check("out_valid", bus.out_valid, e_valid);
    check("out_instr", bus.out_instr, e_instr);
    check("out_pc_plus4", bus.out_pc_plus4, e_p4);
    check("occupancy", bus.occupancy, n);
    took = le && e_valid;
    if (br) begin
      q.delete();
      m_pc = tgt;
    end else if (took && !from_q) begin
      m_pc = m_pc + 8'd4;
    end else begin
      if (took) q.delete(0);
      if (n < DEPTH || took) begin
        q.push_back('{instr: rom(m_pc), pc_plus4: m_pc + 8'd4});
        m_pc = m_pc + 8'd4;
      end
    end
    @(negedge clk);
  endtask
  task automatic check_reset();
    check("rst_rom_addr", bus.rom_addr, 32'h0);
    check("rst_out_valid", bus.out_valid, 32'h0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check("rst_out_pc_plus4", bus.out_pc_plus4, 32'h0);
    check("rst_occupancy", bus.occupancy, 32'h0);
  endtask
  initial begin
    bus.id_le = 1'b0;
    bus.br_take = 1'b0;
    bus.br_target = 8'h00;
    #1;
    check_reset();
    @(negedge clk);
    R_n = 1'b1;
    step(0, 1, 8'h10);
    repeat (3) step(0, 0, 8'h00);
    check("pre_rst_rom_addr", bus.rom_addr, 32'h1C);
    check("pre_rst_occupancy", bus.occupancy, 32'd3);
    #1 R_n = 1'b0;
    #1;
    check_reset();
    q.delete();
    m_pc = 8'h00;
    @(negedge clk);
    R_n = 1'b1;
    repeat (6) step(0, 0, 8'h00);
    check("fill_rom_addr", bus.rom_addr, 32'h10);
    check("fill_occupancy", bus.occupancy, 32'd4);
    check("fill_head", bus.out_instr, 32'hA5A5A500);
    check("fill_head_pc4", bus.out_pc_plus4, 32'h04);
    repeat (8) step(1, 0, 8'h00);
    check("stream_occupancy", bus.occupancy, 32'd4);
    step(0, 1, 8'h20);
    repeat (3) step(0, 0, 8'h00);
    check("flush_pre_occupancy", bus.occupancy, 32'd3);
    step(1, 1, 8'h40);
    check("flush_occupancy", bus.occupancy, 32'd0);
    check("flush_rom_addr", bus.rom_addr, 32'h40);
    step(0, 0, 8'h00);
    check("flush_head", bus.out_instr, 32'hA5A5A540);
    step(0, 1, 8'hFC);
    step(0, 0, 8'h00);
    check("wrap_rom_addr", bus.rom_addr, 32'h00);
    check("wrap_head_pc4", bus.out_pc_plus4, 32'h00);
    check("wrap_valid", bus.out_valid, 32'd1);
    step(0, 1, 8'h80);
    bus.id_le = 1'b1;
    #1;
    check("byp_same_cycle_valid", bus.out_valid, {31'd0, BYP});
    check("byp_occupancy", bus.occupancy, 32'd0);
    step(1, 0, 8'h00);
    check("byp_next_valid", bus.out_valid, 32'd1);
    check("byp_next_occupancy", bus.occupancy, BYP ? 32'd0 : 32'd1);
    repeat (400) step(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, {6'($urandom), 2'b00});
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
